// File: rtl/bgp_startup_seq.sv
// Bandgap startup sequencer: powers channels up one at a time, waits a settling window,
// verifies each channel's comparator flag and supervises ON channels for dropout.
module bgp_startup_seq #(
    parameter int unsigned       CHANNELS      = 4,
    parameter int unsigned       SETTLE_CYCLES = 1024,
    parameter int unsigned       CNT_W         = 11,
    parameter int unsigned       TRIM_W        = 5,
    parameter logic [TRIM_W-1:0] TRIM_DEFAULT  = 5'd16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [CHANNELS-1:0] en_req,
    input  logic [CHANNELS-1:0] vbgp_ok,
    input  logic [TRIM_W-1:0]   trim_in,
    input  logic                trim_load,
    output logic [CHANNELS-1:0] bgp_en,
    output logic [TRIM_W-1:0]   bgp_trim,
    output logic [CHANNELS-1:0] ready,
    output logic [CHANNELS-1:0] fault,
    output logic                busy
);

    localparam int unsigned      IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck
    } seq_state_e;

    typedef enum logic [1:0] {
        ChOff,
        ChStarting,
        ChOn,
        ChFault
    } ch_state_e;

    seq_state_e          r_state;
    ch_state_e           r_stat [CHANNELS];
    logic [IDX_W-1:0]    r_cur;
    logic [CNT_W-1:0]    r_cnt;
    logic [CHANNELS-1:0] r_bgp_en;
    logic [CHANNELS-1:0] r_ready;
    logic [CHANNELS-1:0] r_fault;
    logic                r_busy;
    logic [TRIM_W-1:0]   r_trim;

    logic                w_found;
    logic [IDX_W-1:0]    w_cand;
    logic                w_any_starting;
    logic                w_trim_ok;

    // Lowest-index requesting OFF channel is the next one to power up.
    always_comb begin
        w_found        = 1'b0;
        w_cand         = '0;
        w_any_starting = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!w_found && en_req[i] && (r_stat[i] == ChOff)) begin
                w_found = 1'b1;
                w_cand  = IDX_W'(i);
            end
            if (r_stat[i] == ChStarting) begin
                w_any_starting = 1'b1;
            end
        end
    end

    // A strobe that coincides with a channel start is dropped so trim never moves mid-settle.
    assign w_trim_ok = trim_load && (r_state == StIdle) && !w_found && !w_any_starting;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= StIdle;
            r_cur    <= '0;
            r_cnt    <= '0;
            r_bgp_en <= '0;
            r_ready  <= '0;
            r_fault  <= '0;
            r_busy   <= 1'b0;
            r_trim   <= TRIM_DEFAULT;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_stat[i] <= ChOff;
            end
        end else begin
            // ON/FAULT channels are supervised independently of the sequencer.
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (r_stat[i] == ChOn) begin
                    if (!en_req[i]) begin
                        r_stat[i]   <= ChOff;
                        r_bgp_en[i] <= 1'b0;
                        r_ready[i]  <= 1'b0;
                    end else if (!vbgp_ok[i]) begin
                        r_stat[i]   <= ChFault;
                        r_bgp_en[i] <= 1'b0;
                        r_ready[i]  <= 1'b0;
                        r_fault[i]  <= 1'b1;
                    end
                end else if ((r_stat[i] == ChFault) && !en_req[i]) begin
                    r_stat[i]  <= ChOff;
                    r_fault[i] <= 1'b0;
                end
            end

            if (w_trim_ok) begin
                r_trim <= trim_in;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_cur            <= w_cand;
                        r_bgp_en[w_cand] <= 1'b1;
                        r_stat[w_cand]   <= ChStarting;
                        r_cnt            <= CNT_LOAD;
                        r_state          <= StSettle;
                        r_busy           <= 1'b1;
                    end
                end
                StSettle: begin
                    if (!en_req[r_cur]) begin
                        r_bgp_en[r_cur] <= 1'b0;
                        r_stat[r_cur]   <= ChOff;
                        r_state         <= StIdle;
                        r_busy          <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= StCheck;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StCheck: begin
                    if (!en_req[r_cur]) begin
                        r_bgp_en[r_cur] <= 1'b0;
                        r_stat[r_cur]   <= ChOff;
                    end else if (vbgp_ok[r_cur]) begin
                        r_stat[r_cur]  <= ChOn;
                        r_ready[r_cur] <= 1'b1;
                    end else begin
                        r_stat[r_cur]   <= ChFault;
                        r_fault[r_cur]  <= 1'b1;
                        r_bgp_en[r_cur] <= 1'b0;
                    end
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bgp_en   = r_bgp_en;
    assign bgp_trim = r_trim;
    assign ready    = r_ready;
    assign fault    = r_fault;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bgp_startup_seq.sv
// Directed bench for bgp_startup_seq with 4 channels and an 8-cycle settling window.
module tb_bgp_startup_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en_req;
    logic [3:0] vbgp_ok;
    logic [4:0] trim_in;
    logic       trim_load;
    logic [3:0] bgp_en;
    logic [4:0] bgp_trim;
    logic [3:0] ready;
    logic [3:0] fault;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bgp_startup_seq #(
        .CHANNELS     (4),
        .SETTLE_CYCLES(8),
        .CNT_W        (4),
        .TRIM_W       (5),
        .TRIM_DEFAULT (5'd16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en_req   (en_req),
        .vbgp_ok  (vbgp_ok),
        .trim_in  (trim_in),
        .trim_load(trim_load),
        .bgp_en   (bgp_en),
        .bgp_trim (bgp_trim),
        .ready    (ready),
        .fault    (fault),
        .busy     (busy)
    );

    // Inputs change just after a falling edge; outputs are observed at falling edges.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en_req = '0; vbgp_ok = '0; trim_in = '0; trim_load = 1'b0;
        step(2);
        rst = 1'b0;
        n_vec++; if (bgp_en !== 4'b0000) begin n_err++; $display("FAIL reset_bgp_en got=%b exp=0000", bgp_en); end
        n_vec++; if (ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", ready); end
        n_vec++; if (fault !== 4'b0000) begin n_err++; $display("FAIL reset_fault got=%b exp=0000", fault); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (bgp_trim !== 5'd16) begin n_err++; $display("FAIL reset_trim got=%0d exp=16", bgp_trim); end
    endtask

    task automatic test_trim_idle();
        trim_in = 5'd3; trim_load = 1'b1;
        step(1);
        trim_load = 1'b0;
        n_vec++; if (bgp_trim !== 5'd3) begin n_err++; $display("FAIL trim_idle got=%0d exp=3", bgp_trim); end
    endtask

    task automatic test_single_start();
        int bcnt;
        en_req = 4'b0001; vbgp_ok = 4'b0001;
        step(1);
        n_vec++; if (bgp_en !== 4'b0001) begin n_err++; $display("FAIL single_en got=%b exp=0001", bgp_en); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
        n_vec++; if (ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_early got=%b exp=0000", ready); end
        bcnt = 1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (busy) bcnt++;
            else break;
        end
        n_vec++; if (bcnt !== 9) begin n_err++; $display("FAIL single_busy_len got=%0d exp=9", bcnt); end
        n_vec++; if (ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got=%b exp=0001", ready); end
    endtask

    task automatic test_sequencing();
        int rise [4];
        en_req = 4'b0000;
        step(1);
        n_vec++; if (bgp_en !== 4'b0000) begin n_err++; $display("FAIL shutdown_en got=%b exp=0000", bgp_en); end
        n_vec++; if (ready !== 4'b0000) begin n_err++; $display("FAIL shutdown_ready got=%b exp=0000", ready); end
        for (int i = 0; i < 4; i++) rise[i] = -1;
        en_req = 4'b1111; vbgp_ok = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                if (bgp_en[i] && (rise[i] < 0)) rise[i] = c;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rise[i] !== 1 + 10 * i) begin
                n_err++; $display("FAIL seq_rise_ch%0d got=%0d exp=%0d", i, rise[i], 1 + 10 * i);
            end
        end
        n_vec++; if (ready !== 4'b1111) begin n_err++; $display("FAIL seq_ready got=%b exp=1111", ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL seq_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_check_fail_retry();
        en_req = 4'b0000;
        step(1);
        en_req = 4'b0011; vbgp_ok = 4'b0001;
        step(11);
        n_vec++; if (bgp_en !== 4'b0011) begin n_err++; $display("FAIL cf_ch1_started got=%b exp=0011", bgp_en); end
        step(9);
        n_vec++; if (fault !== 4'b0010) begin n_err++; $display("FAIL cf_fault got=%b exp=0010", fault); end
        n_vec++; if (bgp_en !== 4'b0001) begin n_err++; $display("FAIL cf_en_off got=%b exp=0001", bgp_en); end
        n_vec++; if (ready !== 4'b0001) begin n_err++; $display("FAIL cf_ready got=%b exp=0001", ready); end
        step(2);
        n_vec++; if (fault !== 4'b0010) begin n_err++; $display("FAIL cf_sticky got=%b exp=0010", fault); end
        en_req = 4'b0001;
        step(1);
        n_vec++; if (fault !== 4'b0000) begin n_err++; $display("FAIL cf_clear got=%b exp=0000", fault); end
        en_req = 4'b0011; vbgp_ok = 4'b0011;
        step(1);
        n_vec++; if (bgp_en !== 4'b0011) begin n_err++; $display("FAIL retry_en got=%b exp=0011", bgp_en); end
        step(8);
        n_vec++; if (ready !== 4'b0001) begin n_err++; $display("FAIL retry_ready_early got=%b exp=0001", ready); end
        step(1);
        n_vec++; if (ready !== 4'b0011) begin n_err++; $display("FAIL retry_ready got=%b exp=0011", ready); end
    endtask

    task automatic test_abort_dropout();
        en_req = 4'b1111; vbgp_ok = 4'b1111;
        step(1);
        n_vec++; if (bgp_en !== 4'b0111) begin n_err++; $display("FAIL ab_start got=%b exp=0111", bgp_en); end
        step(4);
        en_req = 4'b1011;
        step(1);
        n_vec++; if (bgp_en !== 4'b0011) begin n_err++; $display("FAIL ab_en_drop got=%b exp=0011", bgp_en); end
        n_vec++; if (fault !== 4'b0000) begin n_err++; $display("FAIL ab_nofault got=%b exp=0000", fault); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_idle got=%b exp=0", busy); end
        step(1);
        n_vec++; if (bgp_en !== 4'b1011) begin n_err++; $display("FAIL ab_next_ch got=%b exp=1011", bgp_en); end
        step(9);
        n_vec++; if (ready !== 4'b1011) begin n_err++; $display("FAIL ab_ready3 got=%b exp=1011", ready); end
        vbgp_ok = 4'b1110;
        step(1);
        n_vec++; if (ready !== 4'b1010) begin n_err++; $display("FAIL drop_ready got=%b exp=1010", ready); end
        n_vec++; if (fault !== 4'b0001) begin n_err++; $display("FAIL drop_fault got=%b exp=0001", fault); end
        n_vec++; if (bgp_en !== 4'b1010) begin n_err++; $display("FAIL drop_en got=%b exp=1010", bgp_en); end
    endtask

    task automatic test_trim_gating();
        en_req = 4'b1111; trim_in = 5'd20; trim_load = 1'b1;
        step(1);
        trim_load = 1'b0;
        n_vec++; if (bgp_trim !== 5'd3) begin n_err++; $display("FAIL trim_at_start got=%0d exp=3", bgp_trim); end
        n_vec++; if (bgp_en !== 4'b1110) begin n_err++; $display("FAIL trim_start_en got=%b exp=1110", bgp_en); end
        step(2);
        trim_in = 5'd9; trim_load = 1'b1;
        step(1);
        trim_load = 1'b0;
        n_vec++; if (bgp_trim !== 5'd3) begin n_err++; $display("FAIL trim_settle got=%0d exp=3", bgp_trim); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL trim_busy got=%b exp=1", busy); end
    endtask

    task automatic test_reset_mid_settle();
        rst = 1'b1;
        step(1);
        n_vec++; if (bgp_en !== 4'b0000) begin n_err++; $display("FAIL rst_mid_en got=%b exp=0000", bgp_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_vec++; if (fault !== 4'b0000) begin n_err++; $display("FAIL rst_mid_fault got=%b exp=0000", fault); end
        n_vec++; if (ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=0000", ready); end
        n_vec++; if (bgp_trim !== 5'd16) begin n_err++; $display("FAIL rst_mid_trim got=%0d exp=16", bgp_trim); end
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_trim_idle();
        test_single_start();
        test_sequencing();
        test_check_fail_retry();
        test_abort_dropout();
        test_trim_gating();
        test_reset_mid_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing the run");
        $fatal(1);
    end

endmodule

// File: doc/bgp_startup_seq.md
# bgp_startup_seq

Synchronous startup sequencer and supervisor for up to CHANNELS bandgap reference instances in the user area. It turns each channel on one at a time to limit inrush current, holds the channel for a settling window, then checks that channel's analog `vbgp_ok` comparator flag. It reports per-channel ready and fault status and holds a shared trim code for all channels. It sits between management-SoC control logic (logic analyzer or wishbone registers) and the bandgap `EN` and trim pins.

## Interface
- `CHANNELS`, default 4: number of bandgap channels, range 1..16.
- `SETTLE_CYCLES`, default 1024: length of the settling window in clocks, must be ≥1.
- `CNT_W`, default 11: settle counter width, must be ≥ $clog2(SETTLE_CYCLES).
- `TRIM_W`, default 5: trim code width.
- `TRIM_DEFAULT`, default 5'd16: trim value loaded at reset.

Ports:
- `wb_clk_i` input, 1: the only clock; all logic on its rising edge.
- `wb_rst_i` input, 1: synchronous, active-high reset.
- `en_req` input, CHANNELS: per-channel enable request, level.
- `vbgp_ok` input, CHANNELS: per-channel comparator flag, 1 = output in window; already synchronised upstream.
- `trim_in` input, TRIM_W: new trim code.
- `trim_load` input, 1: single-cycle trim load strobe.
- `bgp_en` output, CHANNELS: registered drive to the bandgap `EN` pins.
- `bgp_trim` output, TRIM_W: registered trim code.
- `ready` output, CHANNELS: channel is on and verified.
- `fault` output, CHANNELS: channel failed its check or dropped out; sticky.
- `busy` output, 1: sequencer is not in IDLE.

## Operation
- Per-channel status is one of OFF, STARTING, ON, FAULT. The shared sequencer FSM is IDLE, SETTLE, CHECK, with a current-channel index `cur`.
- All outputs are registered.
- **IDLE:** the candidate is the lowest index i with `en_req[i]`=1 and status OFF. If there is one:
  - set `cur`=i, `bgp_en[i]`=1, status STARTING;
  - load the counter with SETTLE_CYCLES-1;
  - go to SETTLE.
- **SETTLE:**
  - If `en_req[cur]`=0: clear `bgp_en[cur]`, set status OFF, go to IDLE. No fault.
  - Otherwise, if counter==0, go to CHECK; else decrement the counter.
- **CHECK:**
  - If `en_req[cur]`=0: abort exactly as in SETTLE.
  - Otherwise sample `vbgp_ok[cur]`. If 1: status ON, `ready[cur]`=1. If 0: status FAULT, `fault[cur]`=1, `bgp_en[cur]`=0.
  - Go to IDLE in both cases.
- **ON channel (independent of the sequencer):**
  - `en_req`=0: clear `bgp_en` and `ready`, status OFF.
  - Otherwise `vbgp_ok`=0: clear `bgp_en` and `ready`, set `fault`, status FAULT.
  - `en_req` takes priority when both conditions hold in the same cycle.
- **FAULT channel:** it stays off with `fault`=1 until `en_req` is seen low, then it goes OFF with `fault`=0. Reasserting `en_req` queues a retry.
- **Trim:**
  - `trim_load`=1 updates `bgp_trim` from `trim_in` only while the FSM is in IDLE and no channel is STARTING. Otherwise the strobe is dropped, not queued.
  - Trim is never changed during a settling window.
- `busy` = (FSM ≠ IDLE).
- **Reset:** FSM=IDLE, every channel OFF, counter=0, `bgp_en`=0, `ready`=0, `fault`=0, `busy`=0, `bgp_trim`=TRIM_DEFAULT. Reset mid-SETTLE drops `bgp_en` on the next edge.

## Timing
- Start latency: if `en_req[i]` is high and sampled in IDLE at edge t:
  - `bgp_en[i]` and `busy` are 1 after edge t;
  - SETTLE spans edges t+1..t+SETTLE_CYCLES;
  - CHECK is evaluated at edge t+SETTLE_CYCLES+1, when `ready`/`fault` update and the FSM returns to IDLE.
- Back-to-back channels: the next channel's `bgp_en` rises at edge t+SETTLE_CYCLES+2. The per-channel period is SETTLE_CYCLES+2 clocks. Each channel starts at least that many clocks after the previous one.
- Shutdown latency: `en_req` falling is reflected in `bgp_en`/`ready` one edge later, in any status.
- Fault latency: `vbgp_ok` falling on an ON channel sets `fault` and clears `bgp_en` one edge later.
- Simultaneous requests: lower index first; the others wait in OFF.
- A channel whose `en_req` toggles while it is queued is simply re-evaluated at each IDLE cycle.
- `trim_load` in the same cycle that IDLE starts a channel is dropped.

## Test plan
All scenarios use SETTLE_CYCLES=8 and CHANNELS=4.
- **Reset:** hold `wb_rst_i` for 2 clocks -> all outputs 0 and `bgp_trim`=16.
- **Single start:** `en_req`=4'b0001, `vbgp_ok[0]`=1 -> `bgp_en[0]`=1 one clock after sampling; `ready[0]`=1 nine clocks later; `busy` high for exactly 9 clocks.
- **Sequencing:** `en_req`=4'b1111 in one cycle, all `vbgp_ok`=1 -> `bgp_en` bits rise in order 0,1,2,3, spaced 10 clocks apart. Final `ready`=4'b1111.
- **Check fail and retry:**
  - `vbgp_ok[1]`=0 during channel 1's CHECK -> `fault[1]`=1 and `bgp_en[1]`=0.
  - Drop `en_req[1]` for 1 clock, then raise it with `vbgp_ok[1]`=1 -> `fault[1]`=0, then `ready[1]`=1 after 10 clocks.
- **Abort and runtime dropout:**
  - Drop `en_req[2]` at settle count 3 -> `bgp_en[2]`=0 next edge, no fault; FSM moves to channel 3.
  - Pull `vbgp_ok[0]` low on a ready channel 0 -> `ready[0]`=0 and `fault[0]`=1 next edge.
- **Trim gating:**
  - `trim_load` with `trim_in`=5'd3 in IDLE -> `bgp_trim`=3 next edge.
  - `trim_load` with `trim_in`=5'd9 during SETTLE -> `bgp_trim` stays 3.
